// File: rtl/time_keeper.sv
// 12-hour time-of-day counter with a 1 Hz prescaler and a front-panel set mode.
// SET_FIELD selects the field that SW_F2 edits; SW_F1 moves to the next field.
module time_keeper #(
    parameter int TICK_DIV = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TIMESET_RUN,
    input  logic       SW_F1,
    input  logic       SW_F2,
    output logic       AMPM,
    output logic [3:0] HOUR,
    output logic [2:0] MINHIGH,
    output logic [3:0] MINLOW,
    output logic [2:0] SECHIGH,
    output logic [3:0] SECLOW,
    output logic       MIN_TICK,
    output logic [1:0] SET_FIELD
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOUR = 2'd1,
        ST_MIN  = 2'd2,
        ST_AMPM = 2'd3
    } field_e;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    field_e          state_r, state_nx_s;
    logic [PW-1:0]   presc_r, presc_nx_s;
    logic            ampm_r, ampm_nx_s;
    logic [3:0]      hour_r, hour_nx_s;
    logic [2:0]      min_high_r, min_high_nx_s;
    logic [3:0]      min_low_r, min_low_nx_s;
    logic [2:0]      sec_high_r, sec_high_nx_s;
    logic [3:0]      sec_low_r, sec_low_nx_s;
    logic            min_tick_r, min_tick_nx_s;
    logic            sw_f1_d_r, sw_f2_d_r;
    logic            rise_f1_s, rise_f2_s;

    // Hour counts 1..12; 12 wraps to 1.
    function automatic logic [3:0] hour_inc(input logic [3:0] h);
        if (h == 4'd12) begin
            return 4'd1;
        end else begin
            return h + 4'd1;
        end
    endfunction

    assign rise_f1_s = SW_F1 & ~sw_f1_d_r;
    assign rise_f2_s = SW_F2 & ~sw_f2_d_r;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state, prescaler, time chain and set-mode edits
    always_comb begin
        state_nx_s    = state_r;
        presc_nx_s    = presc_r;
        ampm_nx_s     = ampm_r;
        hour_nx_s     = hour_r;
        min_high_nx_s = min_high_r;
        min_low_nx_s  = min_low_r;
        sec_high_nx_s = sec_high_r;
        sec_low_nx_s  = sec_low_r;
        min_tick_nx_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (TIMESET_RUN) begin
                    state_nx_s = ST_HOUR;
                end else begin
                    state_nx_s = ST_RUN;
                end
                if (presc_r == PRESC_MAX) begin
                    presc_nx_s = '0;
                    if (sec_low_r == 4'd9) begin
                        sec_low_nx_s = 4'd0;
                        if (sec_high_r == 3'd5) begin
                            sec_high_nx_s = 3'd0;
                            min_tick_nx_s = 1'b1;
                            if (min_low_r == 4'd9) begin
                                min_low_nx_s = 4'd0;
                                if (min_high_r == 3'd5) begin
                                    min_high_nx_s = 3'd0;
                                    hour_nx_s     = hour_inc(hour_r);
                                    if (hour_r == 4'd11) begin
                                        ampm_nx_s = ~ampm_r;
                                    end else begin
                                        ampm_nx_s = ampm_r;
                                    end
                                end else begin
                                    min_high_nx_s = min_high_r + 3'd1;
                                end
                            end else begin
                                min_low_nx_s = min_low_r + 4'd1;
                            end
                        end else begin
                            sec_high_nx_s = sec_high_r + 3'd1;
                        end
                    end else begin
                        sec_low_nx_s = sec_low_r + 4'd1;
                    end
                end else begin
                    presc_nx_s = presc_r + PW'(1);
                end
            end
            ST_HOUR, ST_MIN, ST_AMPM: begin
                presc_nx_s = '0;
                if (!TIMESET_RUN) begin
                    // Leaving set mode restarts the current minute from :00.
                    state_nx_s    = ST_RUN;
                    sec_high_nx_s = 3'd0;
                    sec_low_nx_s  = 4'd0;
                end else begin
                    if (rise_f2_s) begin
                        case (state_r)
                            ST_HOUR: hour_nx_s = hour_inc(hour_r);
                            ST_MIN: begin
                                if (min_low_r == 4'd9) begin
                                    min_low_nx_s = 4'd0;
                                    if (min_high_r == 3'd5) begin
                                        min_high_nx_s = 3'd0;
                                    end else begin
                                        min_high_nx_s = min_high_r + 3'd1;
                                    end
                                end else begin
                                    min_low_nx_s = min_low_r + 4'd1;
                                end
                            end
                            ST_AMPM: ampm_nx_s = ~ampm_r;
                            default: ampm_nx_s = ampm_r;
                        endcase
                    end else begin
                        hour_nx_s = hour_r;
                    end
                    if (rise_f1_s) begin
                        case (state_r)
                            ST_HOUR: state_nx_s = ST_MIN;
                            ST_MIN:  state_nx_s = ST_AMPM;
                            default: state_nx_s = ST_HOUR;
                        endcase
                    end else begin
                        state_nx_s = state_r;
                    end
                end
            end
            default: begin
                state_nx_s = ST_RUN;
            end
        endcase
    end

    // Time, prescaler, minute pulse and switch history registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_r    <= '0;
            ampm_r     <= 1'b0;
            hour_r     <= 4'd12;
            min_high_r <= 3'd0;
            min_low_r  <= 4'd0;
            sec_high_r <= 3'd0;
            sec_low_r  <= 4'd0;
            min_tick_r <= 1'b0;
            sw_f1_d_r  <= 1'b0;
            sw_f2_d_r  <= 1'b0;
        end else begin
            presc_r    <= presc_nx_s;
            ampm_r     <= ampm_nx_s;
            hour_r     <= hour_nx_s;
            min_high_r <= min_high_nx_s;
            min_low_r  <= min_low_nx_s;
            sec_high_r <= sec_high_nx_s;
            sec_low_r  <= sec_low_nx_s;
            min_tick_r <= min_tick_nx_s;
            sw_f1_d_r  <= SW_F1;
            sw_f2_d_r  <= SW_F2;
        end
    end

    assign AMPM      = ampm_r;
    assign HOUR      = hour_r;
    assign MINHIGH   = min_high_r;
    assign MINLOW    = min_low_r;
    assign SECHIGH   = sec_high_r;
    assign SECLOW    = sec_low_r;
    assign MIN_TICK  = min_tick_r;
    assign SET_FIELD = state_r;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: reference model keeps time as seconds since midnight
// and derives the 12-hour display fields from it arithmetically.
module tb_time_keeper;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TIMESET_RUN = 1'b0;
    logic       SW_F1 = 1'b0;
    logic       SW_F2 = 1'b0;
    logic       AMPM;
    logic [3:0] HOUR;
    logic [2:0] MINHIGH;
    logic [3:0] MINLOW;
    logic [2:0] SECHIGH;
    logic [3:0] SECLOW;
    logic       MIN_TICK;
    logic [1:0] SET_FIELD;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int m_t = 0;       // seconds since midnight, 0..86399
    int m_field = 0;   // 0 run, 1 hour, 2 min, 3 ampm
    int m_pcnt = 0;    // cycles elapsed within the current second
    int m_f1d = 0;
    int m_f2d = 0;
    int m_tick = 0;

    time_keeper #(.TICK_DIV(4)) dut (
        .CLK(CLK), .RST(RST), .TIMESET_RUN(TIMESET_RUN),
        .SW_F1(SW_F1), .SW_F2(SW_F2),
        .AMPM(AMPM), .HOUR(HOUR), .MINHIGH(MINHIGH), .MINLOW(MINLOW),
        .SECHIGH(SECHIGH), .SECLOW(SECLOW), .MIN_TICK(MIN_TICK),
        .SET_FIELD(SET_FIELD)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_hidx();  return (m_t / 3600) % 12; endfunction
    function automatic int m_hour();  return (m_hidx() == 0) ? 12 : m_hidx(); endfunction
    function automatic int m_min();   return (m_t / 60) % 60; endfunction
    function automatic int m_sec();   return m_t % 60; endfunction
    function automatic int m_pm();    return (m_t >= 43200) ? 1 : 0; endfunction

    task automatic model_step(input int r, input int ts, input int f1, input int f2);
        int r1, r2, m;
        if (r != 0) begin
            m_t = 0; m_field = 0; m_pcnt = 0; m_f1d = 0; m_f2d = 0; m_tick = 0;
            return;
        end
        r1 = f1 & ~m_f1d;
        r2 = f2 & ~m_f2d;
        m_tick = 0;
        if (m_field == 0) begin
            m_pcnt++;
            if (m_pcnt == 4) begin
                m_pcnt = 0;
                m_t = (m_t + 1) % 86400;
                if (m_t % 60 == 0) m_tick = 1;
            end
            if (ts != 0) m_field = 1;
        end else begin
            m_pcnt = 0;
            if (ts == 0) begin
                m_field = 0;
                m_t = m_t - (m_t % 60);
            end else begin
                if (r2 != 0) begin
                    if (m_field == 1)
                        m_t = (m_t / 43200) * 43200 + ((m_hidx() + 1) % 12) * 3600 + (m_t % 3600);
                    else if (m_field == 2) begin
                        m = m_min();
                        m_t = m_t - m * 60 + ((m + 1) % 60) * 60;
                    end else
                        m_t = (m_t + 43200) % 86400;
                end
                if (r1 != 0) m_field = (m_field == 3) ? 1 : m_field + 1;
            end
        end
        m_f1d = f1;
        m_f2d = f2;
    endtask

    task automatic check_all();
        check("ampm",      int'(AMPM),      m_pm());
        check("hour",      int'(HOUR),      m_hour());
        check("minhigh",   int'(MINHIGH),   m_min() / 10);
        check("minlow",    int'(MINLOW),    m_min() % 10);
        check("sechigh",   int'(SECHIGH),   m_sec() / 10);
        check("seclow",    int'(SECLOW),    m_sec() % 10);
        check("min_tick",  int'(MIN_TICK),  m_tick);
        check("set_field", int'(SET_FIELD), m_field);
    endtask

    task automatic cyc(input logic r, input logic ts, input logic a, input logic b);
        RST = r; TIMESET_RUN = ts; SW_F1 = a; SW_F2 = b;
        @(posedge CLK);
        model_step(int'(r), int'(ts), int'(a), int'(b));
        #1;
        check_all();
    endtask

    task automatic press(input logic a, input logic b);
        cyc(1'b0, 1'b1, a, b);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // run n cycles, return number of MIN_TICK pulses seen
    task automatic run(input int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (MIN_TICK) ticks++;
        end
    endtask

    // enter set mode, dial in h:m with am/pm, exit back to RUN
    task automatic set_time(input int h, input int m, input int pm);
        int n;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        n = ((h % 12) - m_hidx() + 12) % 12;
        for (int i = 0; i < n; i++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        n = (m - m_min() + 60) % 60;
        for (int i = 0; i < n; i++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        if (m_pm() != pm) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int ticks;
        int hold;
        logic ts;

        // 1: reset value and first second
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_hour", int'(HOUR), 12);
        check("rst_field", int'(SET_FIELD), 0);
        run(4, ticks);
        check("first_sec", int'(SECLOW), 1);
        run(236, ticks);
        check("run_min", int'(MINLOW), 1);
        check("run_sec", int'(SECLOW), 0);
        check("run_ticks", ticks, 1);

        // 2: hour / AM-PM rollovers
        set_time(11, 59, 1);
        run(240, ticks);
        check("pm_to_am_hour", int'(HOUR), 12);
        check("pm_to_am_ampm", int'(AMPM), 0);
        check("pm_to_am_ticks", ticks, 1);
        set_time(11, 59, 0);
        run(240, ticks);
        check("am_to_pm_hour", int'(HOUR), 12);
        check("am_to_pm_ampm", int'(AMPM), 1);
        set_time(12, 59, 1);
        run(240, ticks);
        check("12_to_1_hour", int'(HOUR), 1);
        check("12_to_1_ampm", int'(AMPM), 1);

        // 3: set-mode editing from reset
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
        check("set_hour3", int'(HOUR), 3);
        press(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("held_f2_min", int'(MINLOW), 1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("set_ampm", int'(AMPM), 1);
        press(1'b1, 1'b0);
        check("field_wrap", int'(SET_FIELD), 1);

        // 4: minute 59->00 without hour carry, hour 12->1 without AM/PM change
        press(1'b1, 1'b0);
        for (int i = 0; i < 58; i++) press(1'b0, 1'b1);
        check("min59", int'(MINHIGH) * 10 + int'(MINLOW), 59);
        press(1'b0, 1'b1);
        check("min_wrap", int'(MINHIGH) * 10 + int'(MINLOW), 0);
        check("min_wrap_hour", int'(HOUR), 3);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) press(1'b0, 1'b1);
        check("hour12", int'(HOUR), 12);
        press(1'b0, 1'b1);
        check("hour_wrap", int'(HOUR), 1);
        check("hour_wrap_ampm", int'(AMPM), 1);

        // 5: simultaneous F1/F2 in HOUR, then switches ignored in RUN
        press(1'b1, 1'b1);
        check("simul_hour", int'(HOUR), 2);
        check("simul_field", int'(SET_FIELD), 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("run_ignore_min", int'(MINLOW), 0);

        // 6: reset mid-set, then seconds clear on exit
        set_time(5, 37, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        check("pre_rst_field", int'(SET_FIELD), 2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_mid_hour", int'(HOUR), 12);
        check("rst_mid_field", int'(SET_FIELD), 0);
        run(10, ticks);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("exit_sec", int'(SECLOW), 0);
        run(3, ticks);
        check("exit_sec_3", int'(SECLOW), 0);
        run(1, ticks);
        check("exit_sec_4", int'(SECLOW), 1);

        // randomized phase: slowly varying mode, random switches, rare reset
        ts = 1'b0;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                ts = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
                hold = $urandom_range(5, 120);
            end else begin
                hold--;
            end
            cyc(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0, ts,
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Upstream timekeeping stage of the digital clock; produces the 12-hour time (AMPM/HOUR/MINHIGH/MINLOW) that the alarm block compares against and that the display consumes.
- Divides CLK to a 1 Hz second tick and counts seconds, minutes and hours in 12-hour format.
- Provides a user set mode driven by the shared SW_F1/SW_F2 front-panel switches while TIMESET_RUN is high.

Parameters:
- TICK_DIV, 1000: CLK cycles per second. The bench overrides it to 4.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- TIMESET_RUN  in  1  1 = time-set mode, 0 = run mode
- SW_F1  in  1  field-select switch; acts on rising edge
- SW_F2  in  1  increment switch; acts on rising edge
- AMPM  out  1  0 = AM, 1 = PM
- HOUR  out  4  hour, binary 1..12
- MINHIGH  out  3  minute tens, 0..5
- MINLOW  out  4  minute units, 0..9
- SECHIGH  out  3  second tens, 0..5
- SECLOW  out  4  second units, 0..9
- MIN_TICK  out  1  one-cycle pulse when the minute rolls over in run mode
- SET_FIELD  out  2  0 = RUN, 1 = HOUR, 2 = MIN, 3 = AMPM

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. All state is registered on the CLK rising edge.
- Reset values:
  - Time 12:00:00 AM: AMPM=0, HOUR=12, MINHIGH=0, MINLOW=0, SECHIGH=0, SECLOW=0.
  - MIN_TICK=0, SET_FIELD=0, prescaler=0, switch history registers=0.
  - Reset asserted mid-set returns to RUN with these values.
- Prescaler (RUN only):
  - Counts 0..TICK_DIV-1. The internal tick fires on the cycle the count equals TICK_DIV-1, then the count wraps to 0.
  - In any set state the prescaler is held at 0.
- Second, minute and hour chain (on tick, RUN only):
  - SECLOW 9→0 carries into SECHIGH. SECHIGH 5 with SECLOW 9 → 00 carries into the minute.
  - Minute carry: MINLOW 9→0 carries into MINHIGH. 59→00 carries into the hour.
  - Minute carry also drives MIN_TICK=1 for exactly the cycle after the update edge, i.e. registered with the new minute value.
  - Hour: 12→1 with AMPM unchanged; 11→12 toggles AMPM; otherwise +1.
  - Example: 11:59:59 PM → 12:00:00 AM.
- Switch edges:
  - rise_x = SW_x & ~SW_x_d. SW_x_d is registered every cycle.
  - A held switch produces exactly one action.
  - In RUN, switch edges are ignored.
- Set FSM (SET_FIELD):
  - RUN → HOUR on the cycle TIMESET_RUN is sampled 1.
  - rise_F1 advances HOUR → MIN → AMPM → HOUR.
  - TIMESET_RUN sampled 0 → RUN from any set state. On that same edge seconds clear to 00 and the prescaler is 0, so the first second elapses TICK_DIV cycles later.
- rise_F2 in a set state (update visible one cycle after the edge where it is sampled):
  - HOUR: +1, 12→1, no AMPM change.
  - MIN: MINHIGH:MINLOW +1, 59→00, no hour carry.
  - AMPM: toggle.
  - Set-mode edits never pulse MIN_TICK.
- Simultaneous events:
  - rise_F1 and rise_F2 on the same edge: the increment applies to the field selected before the advance.
  - TIMESET_RUN falling together with a switch edge: the exit wins, and the switch edge is ignored.
  - RST overrides everything.
- Values never leave their legal ranges. No illegal state is reachable.

Test Plan (TICK_DIV=4):
1. Reset, then RUN for 4 cycles → SECLOW=1 after the 4th cycle. After 240 cycles → 12:01:00 AM, with MIN_TICK high for exactly one cycle.
2. Preset via set mode to 11:59 PM, exit, run 240 cycles → 12:00:00 AM, AMPM=0, one MIN_TICK. From 11:59 AM → 12:00 PM (AMPM=1). From 12:59 → 1:00, AMPM unchanged.
3. TIMESET_RUN=1, three SW_F2 pulses → HOUR 12→3. SW_F1, then SW_F2 held 5 cycles → minute +1 only. SW_F1, SW_F2 → AMPM toggles. SW_F1 → SET_FIELD back to 1.
4. In MIN field at 59, SW_F2 → 00 with HOUR unchanged. In HOUR field at 12, SW_F2 → 1 with AMPM unchanged. In set mode, seconds stay frozen and no MIN_TICK occurs.
5. SW_F1 and SW_F2 rise on the same cycle in the HOUR field → HOUR +1 and SET_FIELD=2. In RUN, SW_F2 pulses → no change.
6. RST pulsed while SET_FIELD=2 with time edited to 5:37 PM → next cycle 12:00:00 AM, SET_FIELD=0, MIN_TICK=0. Exiting set mode clears seconds, and the next SECLOW increment comes exactly 4 cycles later.
